// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Optional build macro: MC_CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JR
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_JR     = 2'b11;

  // R-type functs the ALU decoder actually implements (jr is handled by the FSM).
  function automatic logic funct_known(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// R-type ALU decoder: funct field to ALU operation, unknown functs decode as add.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    case (funct)
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory request/ready handshake and wait timeout.
// Optional build macro: MC_CTRL_ILLEGAL_TRAP_EN (illegal opcodes park in TRAP).
module mc_controller
  import mc_pkg::*;
#(
  parameter int WAIT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       memtimeout,
  output logic       illegal
);

  statetype          state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              mem_state;
  logic              timeout;
  logic [2:0]        rtype_alu;

  mc_aludec u_aludec (
    .funct      (funct),
    .alucontrol (rtype_alu)
  );

  assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout   = mem_state && !memready && (wait_cnt == '1);

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (memready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_next = MEMADR;
          OP_RTYPE: begin
            if (funct == FN_JR) state_next = JR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            else if (!funct_known(funct)) state_next = TRAP;
`endif
            else state_next = EXECUTE;
          end
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_ADDI:        state_next = ADDIEX;
          OP_J:           state_next = JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:        state_next = TRAP;
`else
          default:        state_next = FETCH;
`endif
        endcase
      end
      MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        if (memready)     state_next = MEMWB;
        else if (timeout) state_next = FETCH;
      end
      MEMWR:   if (memready || timeout) state_next = FETCH;
      EXECUTE: state_next = ALUWB;
      ADDIEX:  state_next = ADDIWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      TRAP:    state_next = TRAP;
`endif
      default: state_next = FETCH;
    endcase
  end

  // Counter restarts on every entry to a request state, including a timeout retry of FETCH.
  assign wait_next = (mem_state && (state_next == state) && !timeout)
                   ? wait_cnt + WAIT_W'(1) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no state leaves one unassigned (no latch).
    memreq     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PC_ALU;
    pcen       = 1'b0;
    alucontrol = ALU_AND;
    case (state)
      FETCH: begin
        memreq     = 1'b1;
        alusrcb    = SRCB_FOUR;
        alucontrol = ALU_ADD;
        irwrite    = memready;
        pcen       = memready;
      end
      DECODE: begin
        alusrcb    = SRCB_IMMSH;
        alucontrol = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
      end
      MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        memreq   = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        pcen       = (op == OP_BNE) ? ~zero : zero;
      end
      ADDIWB:  regwrite = 1'b1;
      JUMP: begin
        pcsrc = PC_JUMP;
        pcen  = 1'b1;
      end
      JR: begin
        pcsrc = PC_JR;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // An abandoned access must not commit anything.
    if (timeout) begin
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
    // Reset low kills requests and write enables combinationally, not just at the next edge.
    if (!reset) begin
      memreq   = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  assign memtimeout = timeout && reset;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state == TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit: a Moore FSM that sequences the shared datapath (single memory, single ALU, IR/A/B/ALUOut registers) over 3-5 cycles per instruction.
- Supports lw, sw, R-type (add/sub/and/or/slt), jr, beq, bne, addi and j.
- Adds a memory request/ready handshake so the FSM stalls on slow memory.
- Sits beside the multicycle datapath in the top level.

Parameters:
- WAIT_W, 8: width of the memory-wait counter; timeout fires when the counter reaches 2^WAIT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag, valid in BRANCH.
- memready  input  1  memory completes the access this cycle.
- memreq  output  1  memory access request.
- iord  output  1  0 = address from PC, 1 = address from ALUOut.
- irwrite  output  1  load IR.
- memwrite  output  1  store strobe.
- memtoreg  output  1  writeback source is MDR.
- regdst  output  1  1 = rd, 0 = rt.
- regwrite  output  1  register file write enable.
- alusrca  output  1  0 = PC, 1 = A.
- alusrcb  output  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = A (jr).
- pcen  output  1  PC register enable.
- alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- memtimeout  output  1  one-cycle pulse when a memory wait is abandoned.
- illegal  output  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset (reset = 0):
  - state = FETCH, wait counter = 0, illegal = 0.
  - All write enables (irwrite, pcen, regwrite, memwrite) and memreq are forced to 0 while reset is low.
  - First fetch request appears in the first cycle after reset deasserts.
- Reset mid-instruction aborts immediately; no partial write completes.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JR, TRAP.
- FETCH: memreq = 1, iord = 0, alusrca = 0, alusrcb = 01, add, pcsrc = 00.
  - irwrite and pcen are asserted only in the cycle memready = 1; that cycle moves to DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE: alusrca = 0, alusrcb = 11, add (branch target into ALUOut). Next state by op:
  - lw / sw -> MEMADR
  - R-type with funct 001000 -> JR
  - other R-type -> EXECUTE
  - beq / bne -> BRANCH
  - addi -> ADDIEX
  - j -> JUMP
  - anything else -> FETCH, or TRAP when the macro is enabled.
- MEMADR: alusrca = 1, alusrcb = 10, add. Next state MEMRD (lw) or MEMWR (sw).
- MEMRD: memreq = 1, iord = 1. Holds until memready = 1, then MEMWB.
- MEMWB: regdst = 0, memtoreg = 1, regwrite = 1. Next state FETCH.
- MEMWR: memreq = 1, iord = 1, memwrite = 1. Holds until memready = 1, then FETCH.
- EXECUTE: alusrca = 1, alusrcb = 00, alucontrol from funct (unknown funct decodes as add). Next state ALUWB.
- ALUWB: regdst = 1, memtoreg = 0, regwrite = 1. Next state FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, sub, pcsrc = 01.
  - pcen = zero for beq, ~zero for bne.
  - Next state FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, add. Next state ADDIWB.
- ADDIWB: regdst = 0, memtoreg = 0, regwrite = 1. Next state FETCH.
- JUMP: pcsrc = 10, pcen = 1. Next state FETCH.
- JR: pcsrc = 11, pcen = 1. Next state FETCH.
- Wait counter:
  - Cleared on entry to any memreq state.
  - Increments each cycle memreq = 1 and memready = 0.
  - At all-ones with memready still 0: memtimeout pulses, no write enable asserts, next state FETCH. PC is unchanged, so the instruction is retried.
  - If memready and the saturated count occur in the same cycle, memready wins.
- Outputs are pure decodes of state (plus funct/op/zero where stated). Unlisted outputs are 0 in every state.
- Latency (zero-wait memory): lw 5 cycles; sw, R-type, addi 4 cycles; beq, bne, j, jr 3 cycles.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown op in DECODE goes to TRAP.
  - TRAP holds forever with illegal = 1 and all enables at 0; only reset exits.
  - An R-type with undefined funct also traps.
- Undefined: no TRAP state exists; unknown opcodes fall back to FETCH as a NOP (PC already advanced); illegal is tied to 0.

Decomposition:
- Package mc_pkg holds:
  - statetype enum (4-bit),
  - opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_BNE 000101, OP_ADDI 001000, OP_J 000010),
  - funct constants (add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000),
  - ALU control codes,
  - alusrcb/pcsrc encodings.
- Sub-module mc_aludec: combinational funct -> alucontrol, used in EXECUTE only.

Test Plan:
1. memready tied 1, lw $t0,4($0) with mem[4] = 0x1234 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite = 1 with memtoreg = 1 in cycle 5; exactly 5 cycles.
2. beq with zero = 1, then bne with zero = 1 -> pcen = 1 in BRANCH for beq, 0 for bne, pcsrc = 01 both times; each instruction takes 3 cycles.
3. memready held 0 for 3 cycles in FETCH -> irwrite/pcen stay 0 for those 3 cycles, assert in the 4th cycle only, DECODE follows.
4. WAIT_W = 3, memready stuck 0 in MEMRD -> memtimeout pulses once after 7 wait cycles, regwrite never asserts, FETCH follows.
5. Reset driven low during MEMWR with memready = 1 -> memwrite drops to 0 immediately; state FETCH after release.
6. op = 111111 -> with MC_CTRL_ILLEGAL_TRAP_EN: illegal = 1 from the cycle after DECODE and held; without it: back to FETCH, illegal = 0.
